// File: rtl/mem_arbiter86.sv
// Arbitrates the board RAM between the micro86 CPU (stalled via cpu_ce) and fixed-length video bursts.
// Optional ARB_STATS_EN adds stall_cnt/burst_cnt statistics outputs.
module mem_arbiter86 #(
  parameter int AW      = 20,
  parameter int BURST   = 8,
  parameter int CPU_MIN = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [AW-1:0] cpu_a,
  input  logic [7:0]    cpu_o,
  input  logic          cpu_w,
  output logic          cpu_ce,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_a,
  output logic          vid_ack,
  output logic          vid_valid,
  output logic [7:0]    vid_idx,
  output logic [AW-1:0] mem_a,
  output logic [7:0]    mem_d,
  output logic          mem_w
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   burst_cnt
`endif
);

  typedef enum logic [1:0] {ST_CPU, ST_SETUP, ST_BURST, ST_RESTORE} state_t;

  localparam logic [7:0] CPU_MIN_L = 8'(CPU_MIN);
  localparam logic [7:0] LAST_K    = 8'(BURST - 1);

  state_t        state, state_nxt;
  logic [7:0]    gap, gap_inc;
  logic [7:0]    k;
  logic [AW-1:0] base;
  logic          ce_q;

  // gap_inc counts the current CPU cycle too, so a continuous request yields exactly CPU_MIN granted cycles
  assign gap_inc = (gap == CPU_MIN_L) ? gap : gap + 8'd1;
  assign mem_d   = cpu_o;

  always_comb begin
    state_nxt = state;
    cpu_ce    = 1'b0;
    vid_ack   = 1'b0;
    mem_a     = cpu_a;
    mem_w     = 1'b0;
    case (state)
      ST_CPU: begin
        cpu_ce = 1'b1;
        mem_w  = cpu_w & ce_q;
        if (vid_req && (gap_inc == CPU_MIN_L)) state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        vid_ack   = 1'b1;
        mem_w     = cpu_w & ce_q;
        state_nxt = ST_BURST;
      end
      ST_BURST: begin
        mem_a = base + AW'(k);
        if (k == LAST_K) state_nxt = ST_RESTORE;
      end
      ST_RESTORE: state_nxt = ST_CPU;
      default:    state_nxt = ST_CPU;
    endcase
  end

  // ce_q resets low so a write strobe still held by the CPU is never replayed after reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_CPU;
      gap       <= 8'd0;
      k         <= 8'd0;
      base      <= '0;
      ce_q      <= 1'b0;
      vid_valid <= 1'b0;
      vid_idx   <= 8'd0;
    end else begin
      state     <= state_nxt;
      ce_q      <= cpu_ce;
      vid_valid <= (state == ST_BURST);
      vid_idx   <= (state == ST_BURST) ? k : 8'd0;
      case (state)
        ST_CPU:     gap <= gap_inc;
        ST_SETUP: begin
          base <= vid_a;
          k    <= 8'd0;
        end
        ST_BURST:   k <= k + 8'd1;
        ST_RESTORE: gap <= 8'd0;
        default:    gap <= 8'd0;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= 16'd0;
      burst_cnt <= 16'd0;
    end else begin
      if (!cpu_ce && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (state == ST_RESTORE) burst_cnt <= burst_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter86.sv
// Self-checking bench for mem_arbiter86: directed scenarios plus random traffic against a timeline model.
module tb_mem_arbiter86;
  localparam int AW      = 20;
  localparam int BURST   = 8;
  localparam int CPU_MIN = 4;

  logic          clock;
  logic          reset_n;
  logic [AW-1:0] cpu_a;
  logic [7:0]    cpu_o;
  logic          cpu_w;
  logic          cpu_ce;
  logic          vid_req;
  logic [AW-1:0] vid_a;
  logic          vid_ack;
  logic          vid_valid;
  logic [7:0]    vid_idx;
  logic [AW-1:0] mem_a;
  logic [7:0]    mem_d;
  logic          mem_w;
`ifdef ARB_STATS_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   burst_cnt;
`endif

  mem_arbiter86 #(.AW(AW), .BURST(BURST), .CPU_MIN(CPU_MIN)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_a(cpu_a), .cpu_o(cpu_o), .cpu_w(cpu_w), .cpu_ce(cpu_ce),
    .vid_req(vid_req), .vid_a(vid_a), .vid_ack(vid_ack),
    .vid_valid(vid_valid), .vid_idx(vid_idx),
    .mem_a(mem_a), .mem_d(mem_d), .mem_w(mem_w)
`ifdef ARB_STATS_EN
    , .stall_cnt(stall_cnt), .burst_cnt(burst_cnt)
`endif
  );

  initial clock = 1'b0;
  always #20 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: after CPU_MIN granted cycles with a request, a fixed timeline
  // SETUP(+0), bytes (+1..+BURST), RESTORE(+BURST+1) starting at grant_c.
  int            cyc = 0;
  int            grant_c = -1;
  int            cpu_run = 0;
  int            m_off;
  bit            m_stalled;
  logic [AW-1:0] m_base = '0;
  logic          m_ce_q = 1'b0;
  logic          m_cpu_adv = 1'b1;
  logic          m_ack_prev = 1'b0;
  int            m_stall = 0;
  int            m_bursts = 0;
  logic          e_ce, e_ack, e_valid, e_w;
  logic [7:0]    e_idx;
  logic [AW-1:0] e_a;

  // Observations gathered for the directed scenarios
  logic [AW-1:0] burst_addrs[$];
  int            ce_low_count, ack_count, valid_count, wr_count;
  logic [AW-1:0] wr_a;
  logic [7:0]    wr_d;
  bit            track_runs = 0;
  logic          run_val;
  int            run_len;
  int            hi_runs[$];
  int            lo_runs[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_eval();
    m_off     = (grant_c >= 0) ? (cyc - grant_c) : -1;
    m_stalled = (m_off >= 0) && (m_off <= BURST + 1);
    e_ce    = !m_stalled;
    e_ack   = 1'b0;
    e_valid = 1'b0;
    e_idx   = 8'd0;
    e_a     = cpu_a;
    e_w     = 1'b0;
    if (!m_stalled) begin
      e_w = cpu_w & m_ce_q;
    end else begin
      if (m_off == 0) begin
        e_ack  = 1'b1;
        e_w    = cpu_w & m_ce_q;
        m_base = vid_a;
      end else if (m_off <= BURST) begin
        e_a = m_base + AW'(m_off - 1);
      end
      if (m_off >= 2) begin
        e_valid = 1'b1;
        e_idx   = 8'(m_off - 2);
      end
    end
  endtask

  task automatic model_step();
    if (m_stalled) begin
      if (m_stall < 65535) m_stall++;
      if (m_off == BURST + 1) begin
        grant_c  = -1;
        cpu_run  = 0;
        m_bursts = (m_bursts + 1) % 65536;
      end
    end else begin
      cpu_run++;
      if (vid_req && (cpu_run >= CPU_MIN)) grant_c = cyc + 1;
    end
    m_ce_q     = e_ce;
    m_cpu_adv  = e_ce;
    m_ack_prev = e_ack;
    cyc++;
  endtask

  task automatic checkOutput();
    model_eval();
    chk("cpu_ce", 32'(cpu_ce), 32'(e_ce));
    chk("vid_ack", 32'(vid_ack), 32'(e_ack));
    chk("vid_valid", 32'(vid_valid), 32'(e_valid));
    if (e_valid) chk("vid_idx", 32'(vid_idx), 32'(e_idx));
    chk("mem_a", 32'(mem_a), 32'(e_a));
    chk("mem_w", 32'(mem_w), 32'(e_w));
    chk("mem_d", 32'(mem_d), 32'(cpu_o));
`ifdef ARB_STATS_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("burst_cnt", 32'(burst_cnt), 32'(m_bursts));
`endif
    if (m_stalled && m_off >= 1 && m_off <= BURST) burst_addrs.push_back(mem_a);
    if (!cpu_ce) ce_low_count++;
    if (vid_ack) ack_count++;
    if (vid_valid) valid_count++;
    if (mem_w) begin
      wr_count++;
      wr_a = mem_a;
      wr_d = mem_d;
    end
    if (track_runs) begin
      if (cpu_ce === run_val) run_len++;
      else begin
        if (run_val) hi_runs.push_back(run_len);
        else lo_runs.push_back(run_len);
        run_val = cpu_ce;
        run_len = 1;
      end
    end
  endtask

  // One clock cycle: the CPU only changes its outputs after a cycle with cpu_ce=1,
  // and an outstanding video request stays put until it has been acknowledged.
  task automatic applyStimulus(input logic [AW-1:0] a, input logic [7:0] o, input logic w,
                               input logic req, input logic [AW-1:0] va);
    @(posedge clock);
    #1;
    if (m_cpu_adv) begin
      cpu_a = a;
      cpu_o = o;
      cpu_w = w;
    end
    if (!(vid_req && !m_ack_prev)) begin
      vid_req = req;
      if (req) vid_a = va;
    end
    @(negedge clock);
    checkOutput();
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(AW'($urandom), 8'($urandom), 1'b0, 1'b0, '0);
  endtask

  task automatic doReset();
    @(posedge clock);
    #5;
    reset_n = 1'b0;
    cpu_w   = 1'b0;
    vid_req = 1'b0;
    #1;
    chk("rst_cpu_ce", 32'(cpu_ce), 32'd1);
    chk("rst_vid_ack", 32'(vid_ack), 32'd0);
    chk("rst_vid_valid", 32'(vid_valid), 32'd0);
    chk("rst_vid_idx", 32'(vid_idx), 32'd0);
    chk("rst_mem_w", 32'(mem_w), 32'd0);
    chk("rst_mem_a", 32'(mem_a), 32'(cpu_a));
`ifdef ARB_STATS_EN
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_burst_cnt", 32'(burst_cnt), 32'd0);
`endif
    @(negedge clock);
    reset_n    = 1'b1;
    grant_c    = -1;
    cpu_run    = 0;
    m_ce_q     = 1'b0;
    m_cpu_adv  = 1'b1;
    m_ack_prev = 1'b0;
    m_stall    = 0;
    m_bursts   = 0;
    // The half cycle after release is an ordinary CPU cycle for the DUT
    model_eval();
    model_step();
  endtask

  initial begin
    bit found;
    reset_n = 1'b1;
    cpu_a   = '0;
    cpu_o   = 8'd0;
    cpu_w   = 1'b0;
    vid_req = 1'b0;
    vid_a   = '0;
    doReset();

    $display("[TB] idle CPU traffic");
    ack_count = 0;
    ce_low_count = 0;
    for (int i = 0; i < 100; i++)
      applyStimulus(AW'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), 1'b0, '0);
    chk("idle_no_ack", 32'(ack_count), 32'd0);
    chk("idle_ce_high", 32'(ce_low_count), 32'd0);

    $display("[TB] single burst at B8000");
    burst_addrs.delete();
    ce_low_count = 0;
    valid_count = 0;
    applyStimulus(AW'($urandom), 8'($urandom), 1'b0, 1'b1, 20'hB8000);
    for (int i = 0; i < 14; i++) applyStimulus(AW'($urandom), 8'($urandom), 1'b0, 1'b0, '0);
    chk("burst_stall_len", 32'(ce_low_count), 32'(BURST + 2));
    chk("burst_valid_cnt", 32'(valid_count), 32'(BURST));
    chk("burst_nbytes", 32'(burst_addrs.size()), 32'(BURST));
    if (burst_addrs.size() == BURST) begin
      chk("burst_first_a", 32'(burst_addrs[0]), 32'h000B8000);
      chk("burst_last_a", 32'(burst_addrs[7]), 32'h000B8007);
    end

    $display("[TB] write in the request cycle");
    idle(5);
    wr_count = 0;
    applyStimulus(20'h00100, 8'h5A, 1'b1, 1'b1, 20'h12340);
    for (int i = 0; i < 14; i++) applyStimulus(AW'($urandom), 8'($urandom), 1'b0, 1'b0, '0);
    chk("wr1_pulses", 32'(wr_count), 32'd1);
    chk("wr1_addr", 32'(wr_a), 32'h00000100);
    chk("wr1_data", 32'(wr_d), 32'h5A);

    $display("[TB] write completing in SETUP");
    idle(5);
    wr_count = 0;
    applyStimulus(AW'($urandom), 8'($urandom), 1'b0, 1'b1, 20'h23450);
    applyStimulus(20'h00200, 8'hA5, 1'b1, 1'b0, '0);
    for (int i = 0; i < 13; i++) applyStimulus(AW'($urandom), 8'($urandom), 1'b0, 1'b0, '0);
    chk("wr2_pulses", 32'(wr_count), 32'd1);
    chk("wr2_addr", 32'(wr_a), 32'h00000200);
    chk("wr2_data", 32'(wr_d), 32'hA5);

    $display("[TB] continuous request");
    hi_runs.delete();
    lo_runs.delete();
    run_val = 1'b1;
    run_len = 0;
    track_runs = 1;
    for (int i = 0; i < 60; i++) applyStimulus(AW'($urandom), 8'($urandom), 1'b0, 1'b1, 20'h40000);
    for (int i = 0; i < 30; i++) applyStimulus(AW'($urandom), 8'($urandom), 1'b0, 1'b0, '0);
    track_runs = 0;
    chk("cont_hi_runs", 32'(hi_runs.size() >= 4), 32'd1);
    chk("cont_lo_runs", 32'(lo_runs.size() >= 4), 32'd1);
    for (int i = 1; i < hi_runs.size(); i++) chk("cont_cpu_len", 32'(hi_runs[i]), 32'(CPU_MIN));
    for (int i = 0; i < lo_runs.size(); i++) chk("cont_stall_len", 32'(lo_runs[i]), 32'(BURST + 2));

    $display("[TB] address wrap");
    idle(5);
    burst_addrs.delete();
    applyStimulus(AW'($urandom), 8'($urandom), 1'b0, 1'b1, 20'hFFFFC);
    for (int i = 0; i < 14; i++) applyStimulus(AW'($urandom), 8'($urandom), 1'b0, 1'b0, '0);
    chk("wrap_nbytes", 32'(burst_addrs.size()), 32'(BURST));
    if (burst_addrs.size() == BURST) begin
      chk("wrap_a3", 32'(burst_addrs[3]), 32'h000FFFFF);
      chk("wrap_a4", 32'(burst_addrs[4]), 32'h00000000);
      chk("wrap_a7", 32'(burst_addrs[7]), 32'h00000003);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++)
      applyStimulus(AW'($urandom), 8'($urandom), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 5) == 0), AW'($urandom));

    $display("[TB] reset during burst byte 3");
    idle(6);
    found = 0;
    applyStimulus(AW'($urandom), 8'($urandom), 1'b0, 1'b1, 20'h00ABC);
    for (int i = 0; i < 30 && !found; i++) begin
      if (grant_c >= 0 && (cyc - grant_c) == 4) found = 1;
      else applyStimulus(AW'($urandom), 8'($urandom), 1'b0, 1'b0, '0);
    end
    chk("rst_reached_byte3", 32'(found), 32'd1);
    chk("rst_pre_valid", 32'(vid_valid), 32'd1);
    doReset();
    wr_count = 0;
    for (int i = 0; i < 40; i++)
      applyStimulus(AW'($urandom), 8'($urandom), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 4) == 0), AW'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
